// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: assembles a little-endian byte stream
// (word-count header, then payload words) into 32-bit writes at addresses 0..N-1.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [31:0]           checksum_o
);

    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_FIN
    } state_e;

    state_e           state_q;
    logic [1:0]       byte_cnt_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] n_words_q;
    logic [23:0]      shift_q;

    logic [31:0]      word_c;
    logic [CNT_W-1:0] word_cnt_d;
    logic             last_byte_c;

    // The incoming byte lands in the top lane; after four bytes the first one is the LSB.
    assign word_c      = {rx_data_i, shift_q};
    assign word_cnt_d  = word_cnt_q + CNT_W'(1);
    assign last_byte_c = rx_valid_i && (byte_cnt_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            n_words_q   <= '0;
            shift_q     <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            checksum_o  <= '0;
        end else begin
            mem_we_o <= 1'b0;
            done_o   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_HEADER;
                        busy_o     <= 1'b1;
                        byte_cnt_q <= 2'd0;
                        word_cnt_q <= '0;
                        checksum_o <= '0;
                        error_o    <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (rx_valid_i) begin
                        shift_q    <= word_c[31:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    if (last_byte_c) begin
                        n_words_q <= word_c[CNT_W-1:0];
                        if (word_c == 32'd0) begin
                            // Empty load: the pulse is raised on entry to FIN.
                            state_q <= S_FIN;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                        end else if ({1'b0, word_c} > CAPACITY) begin
                            state_q <= S_IDLE;
                            error_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        shift_q    <= word_c[31:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    if (last_byte_c) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= word_cnt_q[ADDR_WIDTH-1:0];
                        mem_wdata_o <= word_c;
                        checksum_o  <= checksum_o + word_c;
                        word_cnt_q  <= word_cnt_d;
                        if (word_cnt_d == n_words_q) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    // After a data load the pulse trails the final write; after an
                    // empty load it was already raised, so it drops here.
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= ~done_o;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of complete loads plus hand-written
// sequences for oversize header, idle/busy noise and reset mid-load.
module tb_program_loader;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   checksum;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .checksum_o  (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled on the falling edge.
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    int            wc_q [$];
    int            done_n  = 0;
    int            done_at = -1;
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_n  <= done_n + 1;
            done_at <= cyc;
        end
    end

    typedef struct {
        logic [31:0] n;
        int          nw;
        logic [31:0] w [4];
        logic [31:0] csum;
        int          gap;
    } vec_t;

    vec_t        vt [5];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] wbuf [16];
    int          wcyc [16];
    int          hdr_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [31:0] n, input int nw,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input logic [31:0] csum, input int gap);
        vt[idx].n    = n;
        vt[idx].nw   = nw;
        vt[idx].w[0] = w0;
        vt[idx].w[1] = w1;
        vt[idx].w[2] = w2;
        vt[idx].w[3] = w3;
        vt[idx].csum = csum;
        vt[idx].gap  = gap;
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            drive_byte(w[8*i +: 8]);
            last_cyc = cyc;
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic run_load(input logic [31:0] n, input int nw, input int gap);
        pulse_start();
        send_word(n, gap, hdr_cyc);
        for (int i = 0; i < nw; i++) send_word(wbuf[i], gap, wcyc[i]);
    endtask

    task automatic check_load(input string name, input int nw, input logic [31:0] csum,
                              input int we0, input int dn0);
        int exp_done;
        check($sformatf("%s writes", name), 64'(wa_q.size() - we0), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            if (we0 + i < wa_q.size()) begin
                check($sformatf("%s addr[%0d]", name, i), 64'(wa_q[we0+i]), 64'(i));
                check($sformatf("%s data[%0d]", name, i), 64'(wd_q[we0+i]), 64'(wbuf[i]));
                check($sformatf("%s we_cycle[%0d]", name, i), 64'(wc_q[we0+i]), 64'(wcyc[i]));
            end
        end
        if (nw == 0) exp_done = hdr_cyc;
        else         exp_done = wcyc[nw-1] + 1;
        check($sformatf("%s done_count", name), 64'(done_n - dn0), 64'd1);
        check($sformatf("%s done_cycle", name), 64'(done_at), 64'(exp_done));
        check($sformatf("%s checksum", name), 64'(checksum), 64'(csum));
        check($sformatf("%s busy", name), 64'(busy), 64'd0);
        check($sformatf("%s error", name), 64'(error), 64'd0);
    endtask

    initial begin
        int we0;
        int dn0;
        int tmp;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Word sums wrap modulo 2^32 in vector 2.
        set_vec(0, 32'd2, 2, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 32'hF0E21567, 1);
        set_vec(1, 32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        set_vec(2, 32'd4, 4, 32'h80000000, 32'h80000001, 32'hFFFFFFFF, 32'h00000005, 32'h5, 0);
        set_vec(3, 32'd1, 1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 2);
        set_vec(4, 32'd3, 3, 32'h1, 32'h2, 32'h3, 32'h0, 32'h6, 0);

        idle(3);
        reset = 1'b0;
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst error", 64'(error), 64'd0);
        check("rst checksum", 64'(checksum), 64'd0);

        for (int v = 0; v < 5; v++) begin
            we0 = wa_q.size();
            dn0 = done_n;
            for (int i = 0; i < 4; i++) wbuf[i] = vt[v].w[i];
            run_load(vt[v].n, vt[v].nw, vt[v].gap);
            idle(3);
            check_load($sformatf("vec%0d", v), vt[v].nw, vt[v].csum, we0, dn0);
        end

        // Oversize header: N = 17 exceeds a 16-word memory.
        we0 = wa_q.size();
        dn0 = done_n;
        pulse_start();
        check("ovf busy_after_start", 64'(busy), 64'd1);
        send_word(32'd17, 0, hdr_cyc);
        check("ovf error_rise", 64'(error), 64'd1);
        check("ovf busy_fall", 64'(busy), 64'd0);
        idle(2);
        check("ovf error_sticky", 64'(error), 64'd1);
        send_word(32'hA1B2C3D4, 0, tmp);
        send_word(32'h00000001, 1, tmp);
        idle(3);
        check("ovf/idle writes", 64'(wa_q.size() - we0), 64'd0);
        check("ovf/idle done", 64'(done_n - dn0), 64'd0);
        check("ovf/idle busy", 64'(busy), 64'd0);

        // N = 16 fills memory exactly; the accepted start clears error.
        we0 = wa_q.size();
        dn0 = done_n;
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h10000000 + 32'(i);
        pulse_start();
        check("fill error_cleared", 64'(error), 64'd0);
        send_word(32'd16, 0, hdr_cyc);
        for (int i = 0; i < 16; i++) send_word(wbuf[i], 0, wcyc[i]);
        idle(3);
        check_load("fill16", 16, 32'h00000078, we0, dn0);

        // start with rx_valid in IDLE drops the byte; a start mid-DATA is ignored.
        we0 = wa_q.size();
        dn0 = done_n;
        wbuf[0] = 32'hCAFEF00D;
        wbuf[1] = 32'h00000001;
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        send_word(32'd2, 1, hdr_cyc);
        drive_byte(8'h0D);
        drive_byte(8'hF0);
        pulse_start();
        drive_byte(8'hFE);
        drive_byte(8'hCA);
        wcyc[0] = cyc;
        send_word(wbuf[1], 1, wcyc[1]);
        idle(3);
        check_load("noise", 2, 32'hCAFEF00E, we0, dn0);

        // Reset after six data bytes of a three-word load.
        we0 = wa_q.size();
        dn0 = done_n;
        pulse_start();
        send_word(32'd3, 0, hdr_cyc);
        send_word(32'h01020304, 0, tmp);
        drive_byte(8'h55);
        drive_byte(8'h66);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst mem_we", 64'(mem_we), 64'd0);
        check("midrst mem_addr", 64'(mem_addr), 64'd0);
        check("midrst mem_wdata", 64'(mem_wdata), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst error", 64'(error), 64'd0);
        check("midrst checksum", 64'(checksum), 64'd0);
        drive_byte(8'h77);
        drive_byte(8'h88);
        idle(4);
        check("midrst writes", 64'(wa_q.size() - we0), 64'd1);
        if (wa_q.size() > we0) begin
            check("midrst addr0", 64'(wa_q[we0]), 64'd0);
            check("midrst data0", 64'(wd_q[we0]), 64'h01020304);
        end
        check("midrst done_count", 64'(done_n - dn0), 64'd0);

        we0 = wa_q.size();
        dn0 = done_n;
        wbuf[0] = 32'h11223344;
        run_load(32'd1, 1, 0);
        idle(3);
        check_load("after_rst", 1, 32'h11223344, we0, dn0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory. It receives a byte stream from the UART receiver and assembles little-endian 32-bit words. It writes them into the instruction ROM's backing array through a word-addressed write port, so the fetch side can read a freshly loaded program after the loader reports completion. The loader sits between the UART receiver and the instruction memory, and is active only between `start` and `done`/`error`.

## Interface
- `ADDR_WIDTH`, default 13: word-address width of the instruction memory. Capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Honoured only in IDLE.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address of the current write.
- `mem_wdata`  out  32  word being written.
- `busy`  out  1  high in HEADER and DATA.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `error`  out  1  sticky flag for an oversize header. Cleared by `reset` or by an accepted `start`.
- `checksum`  out  32  running sum mod 2^32 of all words written in the current load.

## Operation
- Stream format:
  - 4-byte header N (word count), least-significant byte first.
  - Then N words of 4 bytes each, least-significant byte first.
  - Word k is written to address k, for k = 0..N-1.
- FSM states: IDLE, HEADER, DATA, FIN.
- IDLE:
  - `rx_valid` is ignored.
  - `start` moves to HEADER.
  - On `start`: byte counter=0, word counter=0, `checksum`=0, `error`=0.
- HEADER:
  - Each `rx_valid` shifts `rx_data` into header byte [byte counter], then increments the 2-bit byte counter.
  - On the 4th byte, with N taken from the assembled value:
    - N == 0: go to FIN.
    - N > 2^ADDR_WIDTH: set `error`, go to IDLE.
    - Otherwise: go to DATA.
- DATA:
  - Bytes are assembled into a 32-bit shift register, little-endian.
  - On the 4th byte of a word, the next cycle drives:
    - `mem_we`=1;
    - `mem_addr`=word counter;
    - `mem_wdata`=assembled word;
    - `checksum` += word.
  - On that same 4th byte the word counter increments and the byte counter wraps to 0.
  - When the word just completed is word N-1, go to FIN.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - `start` in HEADER, DATA or FIN is ignored; the load continues.
  - `rx_valid` in FIN is ignored; the byte is dropped.
- There is no timeout. A truncated stream leaves the loader in HEADER or DATA until `reset`.
- Width rules:
  - The word counter is ADDR_WIDTH+1 bits, so N == 2^ADDR_WIDTH is legal and fills memory exactly.
  - `mem_addr` is the low ADDR_WIDTH bits of the counter.

## Timing
- Reset values: state=IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0.
- Reset asserted mid-load aborts immediately. No further `mem_we` is issued after the reset edge, and no `done` pulse follows.
- `busy` rises the cycle after an accepted `start`. It falls in the same cycle `done` pulses, or in the cycle `error` rises.
- Write latency: `mem_we` is high exactly 1 cycle after the `rx_valid` carrying the 4th byte of a word.
- `mem_addr`, `mem_wdata` and `checksum` are registered and stable while `mem_we` is high.
- `done` follows the final `mem_we` by one cycle. With N == 0, `done` is one cycle after the last header byte.
- The loader accepts back-to-back `rx_valid` on every cycle with no stall, so the write port sustains one word per 4 cycles.
- `mem_we` is never asserted outside DATA/FIN transitions and never more than N times per load.

## Test plan
1. `ADDR_WIDTH`=4. Pulse `start`, send header 02 00 00 00, then 78 56 34 12, then EF BE AD DE.
   - Required: `mem_we` at addr 0 with 0x12345678, then at addr 1 with 0xDEADBEEF.
   - Then `done` pulses once, `checksum`=0xF0E21567, `busy`=0.
2. Header 00 00 00 00.
   - Required: no `mem_we`; `done` pulses one cycle after the 4th header byte.
3. `ADDR_WIDTH`=4, header 11 00 00 00 (N=17).
   - Required: `error`=1, back in IDLE, no `done`.
   - Later `start` clears `error`.
   - Header 10 00 00 00 (N=16) loads addresses 0..15.
4. Idle and busy noise.
   - Bytes sent in IDLE cause no writes.
   - A `start` pulsed mid-DATA is ignored; the load completes with the original N.
   - `start` and `rx_valid` in the same IDLE cycle drop that byte.
5. Reset mid-load: N=3, `reset` asserted after 6 data bytes.
   - Required: only addr 0 written, no further `mem_we`, no `done`, all outputs at their reset values.
   - A new load then starts cleanly at addr 0.
6. Back-to-back `rx_valid` every cycle for N=4.
   - Required: `mem_we` exactly every 4 cycles at addrs 0..3, no bytes lost, `checksum` equal to the mod-2^32 sum of the four words.
